// File: rtl/decrypt_out_align.sv
// Re-pairs decrypted data with its ctrl byte and buffers it in a show-ahead FIFO.
// Latency LAT+1 accept-to-out_wr; in_rdy reserves FIFO room for every word still in the decryption pipe.
module decrypt_out_align #(
  parameter int LAT   = 5,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data_ctrl,
  input  logic        in_wr,
  output logic        in_rdy,
  input  logic [63:0] dec_data,
  output logic [63:0] out_data,
  output logic [7:0]  out_ctrl,
  output logic        out_wr,
  input  logic        out_rdy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(LAT + 1);
  localparam int SW = $clog2(DEPTH + LAT + 1);

  logic [LAT-1:0] stage_vld;
  logic [7:0]     stage_ctrl [LAT];
  logic [IW-1:0]  inflight;
  logic [CW-1:0]  fifo_count;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [71:0]    mem [DEPTH];
  logic [71:0]    head;
  logic [SW-1:0]  occupancy;
  logic           accept;
  logic           push;
  logic           pop;

  // Words still inside the decryption pipe already own a FIFO slot.
  assign occupancy = SW'(fifo_count) + SW'(inflight);
  assign in_rdy    = occupancy < SW'(DEPTH);
  assign accept    = in_wr & in_rdy;
  assign push      = stage_vld[LAT-1];
  assign pop       = out_wr;

  assign head     = mem[rd_ptr];
  assign out_wr   = (fifo_count != '0) & out_rdy;
  assign out_data = (fifo_count != '0) ? head[63:0] : 64'd0;
  assign out_ctrl = (fifo_count != '0) ? head[71:64] : 8'd0;

  // Free-running shadow of the decryption pipe; it has no stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_vld <= '0;
      for (int k = 0; k < LAT; k++) stage_ctrl[k] <= 8'd0;
    end else begin
      stage_vld[0]  <= accept;
      stage_ctrl[0] <= accept ? in_data_ctrl : 8'd0;
      for (int k = 1; k < LAT; k++) begin
        stage_vld[k]  <= stage_vld[k-1];
        stage_ctrl[k] <= stage_ctrl[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({accept, push})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: fifo_count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {stage_ctrl[LAT-1], dec_data};
  end

endmodule

// File: doc/decrypt_out_align.md
DECRYPT_OUT_ALIGN -- requirements
Module: decrypt_out_align

Interface
REQ-001 Parameter LAT, default 5: register latency, in cycles, of the decryption pipeline this block is paired with.
REQ-002 Parameter DEPTH, default 8: output FIFO entries; DEPTH >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_data_ctrl  input  8  ctrl byte of the word entering decryption stage 1 this cycle.
REQ-006 in_wr  input  1  upstream write strobe; word enters decryption pipeline and this block in the same cycle.
REQ-007 in_rdy  output  1  upstream may write this cycle.
REQ-008 dec_data  input  64  decryption pipeline output; word accepted in cycle t is valid here in cycle t+LAT.
REQ-009 out_data  output  64  FIFO head data.
REQ-010 out_ctrl  output  8  FIFO head ctrl.
REQ-011 out_wr  output  1  downstream write strobe; one word per asserted cycle.
REQ-012 out_rdy  input  1  downstream can accept a word this cycle.

Function
REQ-013 Accept = in_wr & in_rdy; in_wr while in_rdy=0 SHALL be ignored: no state change, word lost.
REQ-014 Block SHALL keep an LAT-stage shift line of {valid, ctrl[7:0]}, advancing every cycle unconditionally (no stall; the decryption pipeline has no enable).
REQ-015 Stage 1 SHALL load {accept, in_data_ctrl}; stage k loads stage k-1; stage valid=0 carries ctrl=0.
REQ-016 When stage LAT valid=1, block SHALL push {dec_data, stage-LAT ctrl} into the FIFO at that cycle's rising edge.
REQ-017 inflight counter (0..LAT) SHALL count valid stages: +1 on accept, -1 on stage-LAT push, unchanged when both occur together.
REQ-018 in_rdy SHALL be combinational from registers: in_rdy = (fifo_count + inflight) < DEPTH; guarantees no push into a full FIFO.
REQ-019 FIFO SHALL be show-ahead: out_data/out_ctrl present the head entry whenever fifo_count > 0, and 0 when empty.
REQ-020 out_wr SHALL equal (fifo_count > 0) & out_rdy; each out_wr cycle pops the head at the rising edge.
REQ-021 Simultaneous push and pop SHALL leave fifo_count unchanged, data order preserved; push into empty FIFO with out_rdy=1 SHALL NOT bypass (word visible the next cycle).
REQ-022 Read/write pointers SHALL wrap modulo DEPTH; fifo_count range 0..DEPTH.
REQ-023 Latency: word accepted in cycle t SHALL appear with out_wr=1 no earlier than cycle t+LAT+1, exactly t+LAT+1 if FIFO empty and out_rdy=1.
REQ-024 Back-to-back accepts SHALL yield back-to-back out_wr when out_rdy stays 1; sustained throughput one word/cycle.
REQ-025 out_rdy=0 SHALL never drop or duplicate a word; in_rdy deasserts once count+inflight reaches DEPTH.

Reset
REQ-026 reset=1 SHALL immediately clear all shift-stage valid/ctrl, inflight, fifo_count and pointers; out_wr=0, out_data=0, out_ctrl=0, in_rdy=1.
REQ-027 Reset mid-operation SHALL discard in-flight and buffered words; dec_data arriving after reset release for pre-reset words SHALL NOT be pushed.
REQ-028 First accept is permitted in the first cycle after reset deasserts.

Verification
REQ-029 Single word: accept ctrl=0xFF at t, dec_data=0x0123456789ABCDEF at t+5, out_rdy=1 -> out_wr=1 at t+6 with out_data=0x0123456789ABCDEF, out_ctrl=0xFF, one cycle only.
REQ-030 Streaming: 20 consecutive accepts, ctrls 0x00..0x13, out_rdy=1 -> 20 consecutive out_wr cycles starting t+6, ctrl order 0x00..0x13, in_rdy stays 1.
REQ-031 Backpressure: out_rdy=0, in_wr=1 continuously -> exactly 8 accepts, in_rdy=0 after the 8th; release out_rdy -> all 8 words out in order, in_rdy reasserts the cycle after the first pop.
REQ-032 Ignored write: in_wr=1 while in_rdy=0 with ctrl=0xAA -> no 0xAA word ever appears on out_ctrl.
REQ-033 Simultaneous push/pop at fifo_count=8 (full) with out_rdy=1 and stage-5 valid impossible -> count never exceeds 8; at count=4 push+pop keeps count=4.
REQ-034 Reset mid-stream: 3 words in flight plus 2 buffered, pulse reset 1 cycle -> out_wr=0 immediately and for the following 10 cycles with no new accepts; in_rdy=1.
